// File: rtl/pwm_wb_pkg.sv
// Shared definitions for the PWM timer Wishbone host path: bus FSM states,
// register-file map and default bus widths.
package pwm_wb_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_ADR_W  = 16;

  // Register file: 3 channels, 4 words each, channel base = 4*ch
  localparam int NUM_CH    = 3;
  localparam int CH_STRIDE = 4;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PERIOD  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_DC      = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RSP  = 2'd2
  } wb_state_e;

  function automatic logic [WB_ADR_W-1:0] reg_adr(input int unsigned ch,
                                                  input logic [1:0]  off);
    return WB_ADR_W'(ch * CH_STRIDE) + WB_ADR_W'(off);
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Cycle counter for an outstanding strobe; flags expiry when it reaches TIMEOUT-1.
module wb_timeout_cnt #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  assign o_expired = (r_cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_master_cmd.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle out,
// one response back (read data or timeout error). At most one transfer in flight.
module wb_master_cmd
  import pwm_wb_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_W,
  parameter int ADR_WIDTH  = WB_ADR_W,
  parameter int TIMEOUT    = 16,
  parameter int TO_W       = 8
) (
  input  logic                  i_wb_clk,
  input  logic                  i_wb_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_we,
  input  logic [ADR_WIDTH-1:0]  i_cmd_adr,
  input  logic [DATA_WIDTH-1:0] i_cmd_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_err,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADR_WIDTH-1:0]  o_wb_adr,
  output logic [DATA_WIDTH-1:0] o_wb_data,
  input  logic                  i_wb_ack,
  input  logic [DATA_WIDTH-1:0] i_wb_data
);

  wb_state_e             r_state,     w_state_nxt;
  logic                  r_cmd_ready, w_cmd_ready_nxt;
  logic                  r_cyc,       w_cyc_nxt;
  logic                  r_we,        w_we_nxt;
  logic [ADR_WIDTH-1:0]  r_adr,       w_adr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata,     w_wdata_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_data,  w_rsp_data_nxt;
  logic                  r_rsp_err,   w_rsp_err_nxt;
  logic                  w_cnt_clr;
  logic                  w_cnt_en;
  logic                  w_expired;

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .i_clk     (i_wb_clk),
    .i_rst     (i_wb_rst),
    .i_clr     (w_cnt_clr),
    .i_en      (w_cnt_en),
    .o_expired (w_expired)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_cyc       <= w_cyc_nxt;
      r_we        <= w_we_nxt;
      r_adr       <= w_adr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  // NOTE: every signal gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_ready_nxt = 1'b0;
    w_cyc_nxt       = r_cyc;
    w_we_nxt        = r_we;
    w_adr_nxt       = r_adr;
    w_wdata_nxt     = r_wdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;
    w_cnt_clr       = 1'b0;
    w_cnt_en        = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // Ready is registered, so it rises one cycle after re-entering IDLE.
        w_cmd_ready_nxt = 1'b1;
        if (r_cmd_ready && i_cmd_valid) begin
          w_cmd_ready_nxt = 1'b0;
          w_cyc_nxt       = 1'b1;
          w_we_nxt        = i_cmd_we;
          w_adr_nxt       = i_cmd_adr;
          w_wdata_nxt     = i_cmd_data;
          w_cnt_clr       = 1'b1;
          w_state_nxt     = ST_BUS;
        end
      end
      ST_BUS: begin
        w_cnt_en = 1'b1;
        if (i_wb_ack) begin
          w_cyc_nxt       = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = r_we ? '0 : i_wb_data;
          w_rsp_err_nxt   = 1'b0;
          w_state_nxt     = ST_RSP;
        end else if (w_expired) begin
          w_cyc_nxt       = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = '0;
          w_rsp_err_nxt   = 1'b1;
          w_state_nxt     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (i_rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_wb_cyc    = r_cyc;
  assign o_wb_stb    = r_cyc;
  assign o_wb_we     = r_we;
  assign o_wb_adr    = r_adr;
  assign o_wb_data   = r_wdata;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;

endmodule
